// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes used by the encoder, keyer state
// encodings and element lengths expressed in Morse time units.
// Pure definitions; no logic, no timing, no flow control.
package morse_pkg;

    // Symbol codes driven by the letter encoder (code 3 is illegal).
    localparam logic [1:0] MORSE_LGAP = 2'd0;
    localparam logic [1:0] MORSE_DOT  = 2'd1;
    localparam logic [1:0] MORSE_DASH = 2'd2;

    typedef enum logic [1:0] {
        KS_IDLE  = 2'd0,
        KS_LOAD  = 2'd1,
        KS_MARK  = 2'd2,
        KS_SPACE = 2'd3
    } key_state_t;

    // Element lengths in units. LGap only adds the extra two units; the
    // preceding element's own one-unit gap completes the three-unit letter gap.
    localparam logic [1:0] DOT_UNITS        = 2'd1;
    localparam logic [1:0] DASH_UNITS       = 2'd3;
    localparam logic [1:0] ELEM_GAP_UNITS   = 2'd1;
    localparam logic [1:0] LGAP_EXTRA_UNITS = 2'd2;

    function automatic logic [1:0] mark_units(input logic [1:0] sym);
        return (sym == MORSE_DASH) ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// Unit prescaler: counts 0..UNIT_CYCLES-1 and flags the last cycle of each unit.
// Latency: UnitTick is decoded from the counter register (high on the last cycle of a unit).
// No backpressure; Restart forces the counter to 0 on the next edge.
// Ports: Clock, Reset_n (async, active-low), Restart (realign to unit start),
//        UnitTick (high for one cycle per UNIT_CYCLES cycles).
module morse_unit_tick #(
    parameter int UNIT_CYCLES = 25_000_000
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Restart,
    output logic UnitTick
);

    localparam int              CW   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // With UNIT_CYCLES=1 LAST is 0, so every cycle is a tick.
    assign UnitTick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (Restart || UnitTick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: plays one encoder symbol at a time as a timed key mark/space.
// Latency: Key rises on the edge after the LOAD cycle; Advance is high during LOAD.
// Backpressure: the encoder steps only on Advance; Enable low idles after the current element.
// Ports: Clock, Reset_n (async, active-low), Enable, Morse[1:0] in;
//        Key, Advance, Symbol[1:0] (latched symbol), KeyState[1:0] (FSM state) out.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25_000_000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Enable,
    input  logic [1:0] Morse,
    output logic       Key,
    output logic       Advance,
    output logic [1:0] Symbol,
    output logic [1:0] KeyState
);

    key_state_t state_q, state_d;
    logic [1:0] unit_q, unit_d;
    logic [1:0] symbol_q, symbol_d;
    logic       key_q, key_d;
    logic       unit_tick;
    logic       restart;
    logic       elem_done;
    logic [1:0] elem_units;

    morse_unit_tick #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_unit_tick (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Restart  (restart),
        .UnitTick (unit_tick)
    );

    // Length of the element currently playing; only meaningful in MARK/SPACE.
    always_comb begin
        elem_units = ELEM_GAP_UNITS;
        if (state_q == KS_MARK) begin
            elem_units = mark_units(symbol_q);
        end else if (symbol_q == MORSE_LGAP) begin
            elem_units = LGAP_EXTRA_UNITS;
        end
    end

    assign elem_done = unit_tick && (unit_q == elem_units - 2'd1);

    always_comb begin
        state_d  = state_q;
        symbol_d = symbol_q;
        case (state_q)
            KS_IDLE: begin
                if (Enable) begin
                    state_d = KS_LOAD;
                end
            end
            KS_LOAD: begin
                if (Morse == MORSE_DOT || Morse == MORSE_DASH) begin
                    symbol_d = Morse;
                    state_d  = KS_MARK;
                end else begin
                    // Illegal code 3 is played as a letter gap.
                    symbol_d = MORSE_LGAP;
                    state_d  = KS_SPACE;
                end
            end
            KS_MARK: begin
                if (elem_done) begin
                    state_d = KS_SPACE;
                end
            end
            KS_SPACE: begin
                if (elem_done) begin
                    state_d = Enable ? KS_LOAD : KS_IDLE;
                end
            end
            default: begin
                state_d = KS_IDLE;
            end
        endcase
    end

    // Every state change realigns the prescaler and clears the unit count,
    // so each element starts exactly at a unit boundary.
    assign restart = (state_d != state_q);

    always_comb begin
        unit_d = unit_q;
        if (restart || state_q == KS_IDLE || state_q == KS_LOAD) begin
            unit_d = '0;
        end else if (unit_tick) begin
            unit_d = unit_q + 2'd1;
        end
    end

    assign key_d = (state_d == KS_MARK);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= KS_IDLE;
            unit_q   <= '0;
            symbol_q <= MORSE_LGAP;
            key_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            unit_q   <= unit_d;
            symbol_q <= symbol_d;
            key_q    <= key_d;
        end
    end

    assign Key      = key_q;
    assign Advance  = (state_q == KS_LOAD);
    assign Symbol   = symbol_q;
    assign KeyState = state_q;

endmodule
